// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-unit FSM states and a width helper
// for sizing counters from a parameter.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first,
// one bit per clock, with start/ready capture and a one-cycle done pulse.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow
);

    localparam int unsigned     CW       = clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] w_work_next;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_br;
    logic             r_b_out;
    logic             r_overflow;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    full_subtractor u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == LAST_BIT);

    always_comb begin
        w_work_next          = r_work >> 1;
        w_work_next[WIDTH-1] = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_work     <= '0;
            r_diff     <= '0;
            r_cnt      <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_br       <= 1'b0;
            r_b_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= b_in;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                        r_work  <= '0;
                    end
                end
                SHIFT: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_bout;
                    r_work <= w_work_next;
                    // Results load on the edge entering DONE, so the final bit
                    // and borrow are taken straight from the cell, not r_work.
                    if (w_last) begin
                        r_diff     <= w_work_next;
                        r_b_out    <= w_bout;
                        r_overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff     = r_diff;
    assign b_out    = r_b_out;
    assign overflow = r_overflow;

endmodule
